// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch path between the instruction Ram and decode.
package riscv_pkg;

    localparam int InstructionWidth = 32;
    localparam int AddressWidth     = 32;
    localparam int InstructionBytes = 4;

    localparam logic [InstructionWidth-1:0] NopInstruction = 32'h00000013;

    typedef struct packed {
        logic [AddressWidth-1:0]     pc;
        logic [InstructionWidth-1:0] instruction;
    } fetch_entry;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched words with their PCs; flush empties it in one cycle.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   push,
    input  fetch_entry             push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry             head_entry,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = PtrW + 1;

    fetch_entry        slots [Depth];
    logic [PtrW-1:0]   write_ptr;
    logic [PtrW-1:0]   read_ptr;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else if (flush) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) write_ptr <= write_ptr + 1'b1;
            if (pop)  read_ptr  <= read_ptr + 1'b1;
            count <= count + CountW'(push) - CountW'(pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (push && !flush) slots[write_ptr] <= push_entry;
    end

    always_ff @(posedge clock_i) begin
        if (reset_n_i && !flush) assert (!(push && full));
    end

    assign head_entry = slots[read_ptr];
    assign full       = (count == CountW'(Depth));
    assign empty      = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word reads from a synchronous Ram, buffered for decode,
// with a redirect port that flushes the buffer and drops any read still in flight.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [AddressWidth-1:0] ResetVector = 32'h00000000,
    parameter int                      BufferDepth = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    output logic                        read_enable_o,
    output logic [AddressWidth-1:0]     address_o,
    input  logic [InstructionWidth-1:0] data_i,
    input  logic                        redirect_i,
    input  logic [AddressWidth-1:0]     redirect_address_i,
    output logic                        instruction_valid_o,
    output logic [InstructionWidth-1:0] instruction_o,
    output logic [AddressWidth-1:0]     instruction_pc_o,
    input  logic                        instruction_ready_i
);

    localparam int CountW = $clog2(BufferDepth) + 1;
    localparam logic [CountW-1:0] DepthCount = CountW'(BufferDepth);

    logic [AddressWidth-1:0] fetch_pc;
    logic [AddressWidth-1:0] inflight_pc;
    logic                    inflight;
    logic                    issue;
    logic                    transfer;
    logic [CountW-1:0]       count;
    logic                    full;
    logic                    empty;
    fetch_entry              head;
    fetch_entry              incoming;

    // Credits count buffered words plus the one in flight; a same-cycle pop is not credited.
    // Gating with reset keeps the Ram strobe low while reset is held.
    assign issue = reset_n_i && !redirect_i && !full &&
                   ((count + CountW'(inflight)) < DepthCount);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fetch_pc    <= ResetVector;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_address_i[AddressWidth-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + AddressWidth'(InstructionBytes);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign incoming = '{pc: inflight_pc, instruction: data_i};
    assign transfer = !empty && instruction_ready_i;

    fetch_buffer #(
        .Depth (BufferDepth)
    ) buffer (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .push       (inflight),
        .push_entry (incoming),
        .pop        (transfer),
        .flush      (redirect_i),
        .head_entry (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign read_enable_o       = issue;
    assign address_o           = fetch_pc;
    assign instruction_valid_o = !empty;
    assign instruction_o       = empty ? '0 : head.instruction;
    assign instruction_pc_o    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic,
// checked against a queue model of issued-but-not-yet-accepted fetches.
module tb_fetch_unit;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        read_enable_o;
    logic [31:0] address_o;
    logic [31:0] data_i;
    logic        redirect_i;
    logic [31:0] redirect_address_i;
    logic        instruction_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] instruction_pc_o;
    logic        instruction_ready_i;

    always #5 clock_i = ~clock_i;

    fetch_unit #(
        .ResetVector (32'h00000000),
        .BufferDepth (4)
    ) dut (
        .clock_i             (clock_i),
        .reset_n_i           (reset_n_i),
        .read_enable_o       (read_enable_o),
        .address_o           (address_o),
        .data_i              (data_i),
        .redirect_i          (redirect_i),
        .redirect_address_i  (redirect_address_i),
        .instruction_valid_o (instruction_valid_o),
        .instruction_o       (instruction_o),
        .instruction_pc_o    (instruction_pc_o),
        .instruction_ready_i (instruction_ready_i)
    );

    // Synchronous Ram whose word k holds k
    always @(posedge clock_i) begin
        if (read_enable_o) data_i <= address_o >> 2;
    end

    typedef struct {
        logic [31:0] pc;
        int          issued;
    } issue_rec;

    issue_rec    pending[$];
    logic [31:0] next_pc;
    int          now;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] ra);
        logic exp_re;
        logic exp_valid;
        @(negedge clock_i);
        instruction_ready_i = rdy;
        redirect_i          = rd;
        redirect_address_i  = ra;
        #1;
        exp_re    = !rd && (pending.size() < 4);
        exp_valid = 1'b0;
        if (pending.size() > 0) exp_valid = (pending[0].issued <= now - 2);
        chk("read_enable", read_enable_o, exp_re);
        chk("address", address_o, next_pc);
        chk("valid", instruction_valid_o, exp_valid);
        if (exp_valid) begin
            chk("head_pc", instruction_pc_o, pending[0].pc);
            chk("head_instr", instruction_o, pending[0].pc >> 2);
            if (rdy) void'(pending.pop_front());
        end
        if (rd) begin
            pending.delete();
            next_pc = {ra[31:2], 2'b00};
        end else if (exp_re) begin
            pending.push_back('{pc: next_pc, issued: now});
            next_pc = next_pc + 32'd4;
        end
        now++;
    endtask

    // Asserted mid-cycle; outputs must fall without waiting for a clock edge.
    task automatic apply_reset();
        @(negedge clock_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("rst_valid", instruction_valid_o, 32'd0);
        chk("rst_read_enable", read_enable_o, 32'd0);
        chk("rst_address", address_o, 32'h0);
        chk("rst_instr", instruction_o, 32'h0);
        chk("rst_pc", instruction_pc_o, 32'h0);
        repeat (2) @(posedge clock_i);
        #2;
        chk("rst_hold_read_enable", read_enable_o, 32'd0);
        chk("rst_hold_valid", instruction_valid_o, 32'd0);
        reset_n_i = 1'b1;
        pending.delete();
        next_pc = 32'h0;
        now = 0;
    endtask

    initial begin
        logic        rdy;
        logic        rd;
        logic [31:0] ra;
        reset_n_i           = 1'b0;
        redirect_i          = 1'b0;
        redirect_address_i  = 32'h0;
        instruction_ready_i = 1'b1;
        data_i              = 32'h0;
        pending.delete();
        next_pc = 32'h0;
        now = 0;

        // Streaming with ready held high
        apply_reset();
        cycle(1'b1, 1'b0, 32'h0);
        chk("first_issue_addr", address_o, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("first_valid", instruction_valid_o, 32'd1);
        chk("first_pc", instruction_pc_o, 32'h0);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);

        // Back-pressure from reset: four reads, then stall; then drain in order
        apply_reset();
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_addr", address_o, 32'h10);
        chk("stall_head_pc", instruction_pc_o, 32'h0);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);

        // Redirect in cycle 5
        apply_reset();
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h100);
        chk("redir_no_issue", read_enable_o, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_issue_addr", address_o, 32'h100);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_first_pc", instruction_pc_o, 32'h100);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Unaligned redirect and address wrap-around
        cycle(1'b1, 1'b1, 32'h102);
        cycle(1'b1, 1'b0, 32'h0);
        chk("align_addr", address_o, 32'h100);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'hFFFFFFFC);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", address_o, 32'hFFFFFFFC);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", address_o, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Redirect together with push and pop at count 3
        cycle(1'b0, 1'b1, 32'h200);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        chk("full_head_pc", instruction_pc_o, 32'h200);
        cycle(1'b1, 1'b1, 32'h300);
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: the last one wins
        cycle(1'b1, 1'b1, 32'h400);
        cycle(1'b1, 1'b1, 32'h500);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Reset while a word is buffered and a read is in flight
        chk("pre_rst_valid", instruction_valid_o, 32'd1);
        chk("pre_rst_read_enable", read_enable_o, 32'd1);
        apply_reset();
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        // Random ready and redirect traffic
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       ra = $urandom();
                1:       ra = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                default: ra = 32'($urandom_range(0, 1023));
            endcase
            cycle(rdy, rd, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage between the Ram instruction port and the Riscv decode stage. It issues sequential word reads to the synchronous Ram and buffers the returned words with their PCs in a small FIFO. It presents instructions to decode over a valid/ready handshake. Control-flow changes arrive on a redirect port; the redirect flushes the buffer and discards any in-flight read.

Parameters:
ResetVector, 32'h00000000, PC of the first fetch after reset.
BufferDepth, 4, FIFO entries; power of two, at least 2.

Ports:
clock_i  input  1  system clock, rising edge.
reset_n_i  input  1  asynchronous, active-low reset.
read_enable_o  output  1  Ram read strobe.
address_o  output  32  Ram byte address, always word-aligned.
data_i  input  32  Ram read data, valid the cycle after read_enable_o is high.
redirect_i  input  1  one-cycle pulse: flush and restart fetch.
redirect_address_i  input  32  new PC; bits [1:0] are ignored and forced to 0.
instruction_valid_o  output  1  buffer head is valid.
instruction_o  output  32  instruction word at the buffer head.
instruction_pc_o  output  32  PC of instruction_o.
instruction_ready_i  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (asynchronous, reset_n_i low):
  - fetch_pc = ResetVector; FIFO empty; in-flight flag = 0.
  - read_enable_o = 0, instruction_valid_o = 0, instruction_o = 0, instruction_pc_o = 0, address_o = ResetVector. All hold until release.
- State held: fetch_pc (32 bits), inflight (1 bit), inflight_pc (32 bits), FIFO count/pointers.
- Issue rule: read_enable_o = !redirect_i && (count + inflight < BufferDepth).
  - This is combinational from registered state, so it is conservative: a same-cycle pop does not free a credit.
  - address_o = fetch_pc.
  - On issue: fetch_pc += 4, inflight <= 1, inflight_pc <= fetch_pc.
  - Without an issue: inflight <= 0.
- Return: when inflight = 1, data_i is pushed with inflight_pc at the end of that cycle.
- Latency: issue in cycle N -> instruction_valid_o in cycle N+2. The buffer has no bypass.
- Throughput: one instruction per cycle sustained while instruction_ready_i = 1.
- Handshake:
  - A transfer occurs when instruction_valid_o && instruction_ready_i.
  - While valid && !ready, instruction_o and instruction_pc_o stay stable until a redirect.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - The FIFO never overflows by construction. A push into a full FIFO is an assertion failure in simulation.
- Redirect (redirect_i = 1 in cycle R):
  - No issue in R. At the end of R: FIFO cleared, inflight cleared (data_i in R+1 is ignored), fetch_pc = {redirect_address_i[31:2], 2'b00}.
  - A transfer in cycle R still counts as accepted by decode.
  - instruction_valid_o = 0 in R+1 and R+2. The first fetch is issued in R+1, and its valid appears in R+3.
  - A redirect in consecutive cycles: the last one wins.
- Wrap-around:
  - fetch_pc wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
  - FIFO pointers wrap modulo BufferDepth.
- Reset mid-operation: everything is cleared immediately (asynchronously) and the in-flight word is dropped. The first cycle after release issues at ResetVector.

Decomposition:
- Shared package riscv_pkg holds:
  - InstructionWidth = 32, AddressWidth = 32, InstructionBytes = 4.
  - Constant NopInstruction = 32'h00000013.
  - fetch_entry typedef: {pc[31:0], instruction[31:0]}.
- One sub-module: fetch_buffer, a synchronous FIFO of fetch_entry with push, pop, flush, count, full and empty, and the same clock/reset.
- fetch_unit holds the PC, the in-flight tracking and the issue logic.

Test Plan:
- Ram preloaded with word k = k, ready held 1, reset released at cycle 0:
  - Required: read_enable_o = 1 with address 0 in cycle 0.
  - Required: valid in cycle 2 with pc 0/instr 0, then pc 4/instr 1, pc 8/instr 2, one per cycle with no gaps.
- Ready held 0 from reset:
  - Required: exactly 4 reads issued (0, 4, 8, 12), then read_enable_o = 0; head held at pc 0.
  - Then raise ready. Required: pcs 0, 4, 8, 12, 16, ... in order, with no duplicates or drops.
- Redirect_i pulse in cycle 5 with redirect_address_i = 32'h100, ready held 1:
  - Required: read_enable_o = 0 in cycle 5 and valid = 0 in cycles 6-7.
  - Required: address 32'h100 issued in cycle 6 and valid with pc 32'h100 in cycle 8. No pre-redirect pc appears after cycle 5.
- Redirect to 32'h102 -> fetch address 32'h100. Redirect to 32'hFFFFFFFC -> addresses 32'hFFFFFFFC then 32'h00000000.
- Redirect in the same cycle as a push and a pop with the FIFO at count 3 -> count 0 next cycle; the popped entry counts as transferred exactly once.
- reset_n_i driven low mid-cycle (#0.5) while valid = 1 and inflight = 1:
  - Required: valid and read_enable_o drop immediately.
  - Required: after release, fetch restarts at ResetVector and the stale data_i word is never presented.
